// File: rtl/ps2_key_sampler.sv
// PS/2 set-2 keyboard receiver: frames scan codes, translates make codes to ASCII and toggles sample per key.
// Define PS2_SHIFT_EN to track Shift and emit upper-case letters and shifted digit symbols.
`timescale 1ns/1ps
module ps2_key_sampler #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_reg,
    output logic       sample,
    output logic       frame_err,
    output logic       busy
);
    localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DECODE} stateT;

    logic [SYNC_STAGES-1:0] clkPipe, dataPipe;
    logic                   clkPrev;
    logic                   clkSync, dataBit, fall;
    stateT                  state;
    logic [2:0]             bitCnt;
    logic [7:0]             shiftReg;
    logic                   parityBit;
    logic [WDOG_W-1:0]      wdog;
    logic                   brk, ext;
    logic [8:0]             hit;
`ifdef PS2_SHIFT_EN
    logic                   shift;
    logic                   isShift;
`endif

    // Returns {valid, ascii}; the E0 prefix does not change the mapping.
    function automatic logic [8:0] lookupAscii(input logic [8:0] key);
        logic [7:0] a;
        logic       v;
        a = 8'h00;
        v = 1'b1;
        casez (key)
            9'b?_0001_1100: a = 8'h61;  // a
            9'b?_0011_0010: a = 8'h62;
            9'b?_0010_0001: a = 8'h63;
            9'b?_0010_0011: a = 8'h64;
            9'b?_0010_0100: a = 8'h65;
            9'b?_0010_1011: a = 8'h66;
            9'b?_0011_0100: a = 8'h67;
            9'b?_0011_0011: a = 8'h68;
            9'b?_0100_0011: a = 8'h69;
            9'b?_0011_1011: a = 8'h6A;
            9'b?_0100_0010: a = 8'h6B;
            9'b?_0100_1011: a = 8'h6C;
            9'b?_0011_1010: a = 8'h6D;
            9'b?_0011_0001: a = 8'h6E;
            9'b?_0100_0100: a = 8'h6F;
            9'b?_0100_1101: a = 8'h70;
            9'b?_0001_0101: a = 8'h71;
            9'b?_0010_1101: a = 8'h72;
            9'b?_0001_1011: a = 8'h73;
            9'b?_0010_1100: a = 8'h74;
            9'b?_0011_1100: a = 8'h75;
            9'b?_0010_1010: a = 8'h76;
            9'b?_0001_1101: a = 8'h77;
            9'b?_0010_0010: a = 8'h78;
            9'b?_0011_0101: a = 8'h79;
            9'b?_0001_1010: a = 8'h7A;  // z
            9'b?_0100_0101: a = 8'h30;  // 0
            9'b?_0001_0110: a = 8'h31;
            9'b?_0001_1110: a = 8'h32;
            9'b?_0010_0110: a = 8'h33;
            9'b?_0010_0101: a = 8'h34;
            9'b?_0010_1110: a = 8'h35;
            9'b?_0011_0110: a = 8'h36;
            9'b?_0011_1101: a = 8'h37;
            9'b?_0011_1110: a = 8'h38;
            9'b?_0100_0110: a = 8'h39;  // 9
            9'b?_0010_1001: a = 8'h20;  // space
            9'b?_0101_1010: a = 8'h0D;  // enter
            9'b?_0110_0110: a = 8'h08;  // backspace
            default:        v = 1'b0;
        endcase
        return {v, a};
    endfunction

`ifdef PS2_SHIFT_EN
    function automatic logic [7:0] shiftAscii(input logic [7:0] a);
        logic [7:0] s;
        s = a;
        if (a >= 8'h61 && a <= 8'h7A) begin
            s = a - 8'h20;
        end else begin
            case (a)
                8'h30: s = 8'h29;  // )
                8'h31: s = 8'h21;  // !
                8'h32: s = 8'h40;  // @
                8'h33: s = 8'h23;  // #
                8'h34: s = 8'h24;  // $
                8'h35: s = 8'h25;  // %
                8'h36: s = 8'h5E;  // ^
                8'h37: s = 8'h26;  // &
                8'h38: s = 8'h2A;  // *
                8'h39: s = 8'h28;  // (
                default: ;
            endcase
        end
        return s;
    endfunction

    assign isShift = (shiftReg == 8'h12) || (shiftReg == 8'h59);
`endif

    assign clkSync = clkPipe[SYNC_STAGES-1];
    assign dataBit = dataPipe[SYNC_STAGES-1];
    assign fall    = clkPrev & ~clkSync;
    assign hit     = lookupAscii({ext, shiftReg});

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clkPipe   <= '1;
            dataPipe  <= '1;
            clkPrev   <= 1'b1;
            state     <= IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            wdog      <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
`ifdef PS2_SHIFT_EN
            shift     <= 1'b0;
`endif
            key_reg   <= 8'h00;
            sample    <= 1'b1;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            clkPipe   <= {clkPipe[SYNC_STAGES-2:0], ps2_clk};
            dataPipe  <= {dataPipe[SYNC_STAGES-2:0], ps2_data};
            clkPrev   <= clkSync;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (fall && !dataBit) begin
                        state  <= DATA;
                        bitCnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                DECODE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (shiftReg == 8'hF0) begin
                        brk <= 1'b1;
                    end else if (shiftReg == 8'hE0) begin
                        ext <= 1'b1;
                    end else if (brk) begin
                        brk <= 1'b0;
                        ext <= 1'b0;
`ifdef PS2_SHIFT_EN
                        if (isShift) shift <= 1'b0;
`endif
                    end else begin
                        ext <= 1'b0;
`ifdef PS2_SHIFT_EN
                        if (isShift) begin
                            shift <= 1'b1;
                        end else if (hit[8]) begin
                            key_reg <= shift ? shiftAscii(hit[7:0]) : hit[7:0];
                            sample  <= ~sample;
                        end
`else
                        if (hit[8]) begin
                            key_reg <= hit[7:0];
                            sample  <= ~sample;
                        end
`endif
                    end
                end
                default: begin  // DATA, PARITY, STOP share the watchdog
                    if (fall) begin
                        wdog <= '0;
                        if (state == DATA) begin
                            shiftReg <= {dataBit, shiftReg[7:1]};
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) state <= PARITY;
                        end else if (state == PARITY) begin
                            parityBit <= dataBit;
                            state     <= STOP;
                        end else if (dataBit && ^{shiftReg, parityBit}) begin
                            state <= DECODE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        wdog      <= '0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
